spi_agc_sched: RTL and testbench
================================

# spi_agc_sched

SPI write scheduler for the AGC gain interface. Two requesters (the AGC loop and the configuration path) share one SPI write port. The block arbitrates between them round-robin, latches the winning word and shifts it out as one SPI mode-0 frame. It generates SCLK from the system clock through an internal divider and sits between the request sources and the gain device pins.

## Interface
- DATA_W, 16, bits per SPI frame, MSB first; legal range ≥2.
- DIV_N, 2, SCLK half-period in clk cycles; also the CS lead and trail time; legal range ≥1.
- GAP, 4, minimum clk cycles cs_n stays high between frames; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; when low, no new grant is issued and an in-flight frame completes.
- req0  in  1  requester 0 request; held high with data0 stable until ack0.
- data0  in  DATA_W  requester 0 word.
- ack0  out  1  one-cycle pulse: data0 has been latched.
- req1  in  1  requester 1 request; held high with data1 stable until ack1.
- data1  in  DATA_W  requester 1 word.
- ack1  out  1  one-cycle pulse: data1 has been latched.
- grant_id  out  1  requester owning the current or most recent frame.
- busy  out  1  high from grant through the end of GAP.
- done  out  1  one-cycle pulse on the cycle cs_n returns high.
- sclk  out  1  SPI clock; idles low.
- cs_n  out  1  SPI chip select, active low.
- mosi  out  1  SPI data, MSB first.

## Operation
- Reset values (asynchronous, immediate, also mid-frame): state=IDLE, sclk=0, cs_n=1, mosi=0, ack0/ack1=0, done=0, busy=0, grant_id=0, divider=0, bit count=0, last-grant pointer=1 (requester 0 wins the first tie).
- States: IDLE → LEAD → SHIFT → TRAIL → GAP → IDLE.
- **IDLE:**
  - Grant condition: en=1 and (req0|req1).
  - Winner: the only requester asserting; on a tie, the one not granted last.
  - At the granting edge: shift register←data_i, ackᵢ←1, grant_id←i, pointer←i, cs_n←0, mosi←data_i[DATA_W-1], busy←1, state←LEAD.
- **LEAD:** cs_n=0, sclk=0 for DIV_N cycles, then SHIFT.
- **SHIFT:**
  - The divider counts DIV_N cycles per half-period and toggles sclk, starting with a rising edge.
  - On each falling edge except the last: shift left and drive the next bit onto mosi.
  - After the DATA_W-th falling edge (sclk back to 0): state←TRAIL.
- **TRAIL:** hold cs_n=0, sclk=0 for DIV_N cycles. At exit: cs_n←1, done←1, state←GAP.
- **GAP:** cs_n=1 for GAP cycles. At exit: busy←0, state←IDLE.
- While not in IDLE, requests are ignored. A request that stays high is served at the next IDLE evaluation.
- en falling mid-frame has no effect on the current frame. It only blocks the next grant.
- The bit counter width is clog2(DATA_W+1). The divider width is clog2(DIV_N+1). There is no wrap-around beyond the terminal counts.

## Timing
- Grant latency: req sampled high in IDLE → ackᵢ and cs_n low on the following cycle (1 clk).
- cs_n low duration: DIV_N + 2·DATA_W·DIV_N + DIV_N cycles. With defaults this is 68.
- done coincides with the first cs_n-high cycle.
- The earliest next cs_n fall is GAP+1 cycles after done (GAP cycles, plus 1 IDLE grant cycle).
- mosi is stable from DIV_N cycles before each sclk rise until DIV_N cycles after it (mode 0: slave samples on the rise).
- ackᵢ is never asserted while busy was already high in the previous cycle.
- There is exactly one ack per frame.

## Test plan
- Single request: req0=1, data0=16'hA5C3, DIV_N=2.
  - Required: ack0 pulses 1 cycle after req0.
  - cs_n is low for 68 cycles.
  - mosi sampled on 16 sclk rises reads A5C3.
  - done pulses as cs_n rises; busy drops 4 cycles later.
- Simultaneous requests after reset: req0 and req1 held, data0=16'h1111, data1=16'h2222.
  - Required: frames are 1111 then 2222.
  - grant_id is 0 then 1.
  - The second cs_n fall comes 5 cycles after the first done.
- Fairness: req1 held continuously while req0 re-requests after each ack.
  - Required: grants alternate 0,1,0,1 over four frames.
- en gating: en dropped during frame 1 with req1 pending.
  - Required: frame 1 completes intact.
  - No ack1 while en=0.
  - Frame 2 starts 1 cycle after en returns high (when in IDLE).
- Reset mid-SHIFT: rst_n pulled low after 5 bits.
  - Required: cs_n=1, sclk=0, mosi=0, busy=0 immediately.
  - After release, a pending req0 is granted first.
- DIV_N=1, DATA_W=8, data0=8'h81.
  - Required: sclk period is 2 clk.
  - cs_n is low for 18 cycles.
  - mosi reads 81.

Source files
------------

// File: rtl/spi_agc_sched.sv
// Purpose: round-robin SPI mode-0 write scheduler for two gain-word requesters.
// Latency: ack and cs_n fall one clk after a request is sampled in IDLE.
// Backpressure: requests are held until acked; no grant while a frame/gap is in flight or en=0.
module spi_agc_sched #(
  parameter int DATA_W = 16,
  parameter int DIV_N  = 2,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              grant_id,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi
);

  localparam int DW = $clog2(DIV_N + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_N - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] shreg;
  logic              ptr;        // requester granted last; the other wins a tie
  logic              grant;
  logic              win1;
  logic              div_last;
  logic              last_fall;

  assign grant     = en & (req0 | req1);
  assign win1      = req1 & (~req0 | ~ptr);
  assign div_last  = (div_cnt == DIV_LAST);
  // The falling sclk edge that completes the final bit of the frame
  assign last_fall = div_last & sclk & (bit_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: each phase ends on its terminal count
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant)                next_state = S_LEAD;
      S_LEAD:  if (div_last)             next_state = S_SHIFT;
      S_SHIFT: if (last_fall)            next_state = S_TRAIL;
      S_TRAIL: if (div_last)             next_state = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST)  next_state = S_IDLE;
      default:                           next_state = S_IDLE;
    endcase
  end

  // Chip select and busy follow the state directly, so reset forces them idle at once
  always_comb begin
    cs_n = 1'b1;
    busy = 1'b0;
    if (state == S_LEAD || state == S_SHIFT || state == S_TRAIL) begin
      cs_n = 1'b0;
    end
    if (state != S_IDLE) begin
      busy = 1'b1;
    end
  end

  // Datapath: grant latch, divider, sclk generation, shifter and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      ptr      <= 1'b1;
      grant_id <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          gap_cnt <= '0;
          sclk    <= 1'b0;
          if (grant) begin
            shreg    <= win1 ? data1 : data0;
            mosi     <= win1 ? data1[DATA_W-1] : data0[DATA_W-1];
            ack0     <= ~win1;
            ack1     <= win1;
            grant_id <= win1;
            ptr      <= win1;
          end
        end
        S_LEAD: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // Falling edge: advance to the next bit unless this was the last one
            if (sclk && (bit_cnt != BIT_LAST)) begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg << 1;
              mosi    <= shreg[DATA_W-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          if (div_last) begin
            div_cnt <= '0;
            done    <= 1'b1;
            mosi    <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_agc_sched.sv
// Bench for spi_agc_sched: default instance (16-bit, DIV_N=2, GAP=4)
// plus a small instance (8-bit, DIV_N=1) for the fast-clock case.
// Inputs change at negedge+1; outputs are sampled at negedge.
`timescale 1ns/1ps
module tb_spi_agc_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, grant_id, busy, done, sclk, cs_n, mosi;

  logic        b_req0, b_req1;
  logic [7:0]  b_data0, b_data1;
  logic        b_ack0, b_ack1, b_grant_id, b_busy, b_done, b_sclk, b_cs_n, b_mosi;

  spi_agc_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .grant_id(grant_id), .busy(busy), .done(done),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi)
  );

  spi_agc_sched #(.DATA_W(8), .DIV_N(1), .GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
    .grant_id(b_grant_id), .busy(b_busy), .done(b_done),
    .sclk(b_sclk), .cs_n(b_cs_n), .mosi(b_mosi)
  );

  int ntests = 0;
  int nerrs  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor for the default instance ----------------
  int          cyc = 0;
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0;
  logic [15:0] word = '0;
  int          lowcnt = 0, rises = 0;
  logic [15:0] w_q[$];
  int          len_q[$];
  logic        g_q[$];
  int          fall_q[$], done_q[$], bfall_q[$];
  logic        ack_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      p_cs = 1'b1; p_sclk = 1'b0; p_busy = 1'b0;
      word = '0; lowcnt = 0; rises = 0;
    end else begin
      if (p_cs && !cs_n) begin
        fall_q.push_back(cyc);
        word = '0; lowcnt = 0; rises = 0;
      end
      if (!cs_n) begin
        lowcnt++;
        if (sclk && !p_sclk) begin
          word = {word[14:0], mosi};
          rises++;
        end
      end
      if (!p_cs && cs_n) begin
        w_q.push_back(word);
        len_q.push_back(lowcnt);
        g_q.push_back(grant_id);
        chk("done_with_cs_rise", {31'd0, done}, 32'd1);
      end
      if (done) done_q.push_back(cyc);
      if (p_busy && !busy) bfall_q.push_back(cyc);
      if (ack0 || ack1) begin
        ack_q.push_back(ack1);
        chk("ack_while_busy", {31'd0, p_busy}, 32'd0);
      end
      p_cs = cs_n; p_sclk = sclk; p_busy = busy;
    end
  end

  // ---------------- monitor for the small instance ----------------
  int          b_cyc = 0;
  logic        bp_cs = 1'b1, bp_sclk = 1'b0;
  logic [7:0]  b_word = '0;
  int          b_lowcnt = 0, b_rises = 0, b_last_rise = 0, b_badper = 0, b_nper = 0;
  logic [7:0]  bw_q[$];
  int          blen_q[$];

  always @(negedge clk) begin
    b_cyc++;
    if (!rst_n) begin
      bp_cs = 1'b1; bp_sclk = 1'b0;
      b_word = '0; b_lowcnt = 0; b_rises = 0;
    end else begin
      if (bp_cs && !b_cs_n) begin
        b_word = '0; b_lowcnt = 0; b_rises = 0; b_badper = 0; b_nper = 0;
      end
      if (!b_cs_n) begin
        b_lowcnt++;
        if (b_sclk && !bp_sclk) begin
          if (b_rises > 0) begin
            b_nper++;
            if (b_cyc - b_last_rise != 2) b_badper++;
          end
          b_last_rise = b_cyc;
          b_word = {b_word[6:0], b_mosi};
          b_rises++;
        end
      end
      if (!bp_cs && b_cs_n) begin
        bw_q.push_back(b_word);
        blen_q.push_back(b_lowcnt);
        chk("b_done_with_cs_rise", {31'd0, b_done}, 32'd1);
      end
      bp_cs = b_cs_n; bp_sclk = b_sclk;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    w_q.delete(); len_q.delete(); g_q.delete();
    fall_q.delete(); done_q.delete(); bfall_q.delete(); ack_q.delete();
  endtask

  task automatic wait_frames(input int n, input string name);
    int k = 0;
    while (w_q.size() < n && k < 1000) begin
      tick();
      k++;
    end
    chk(name, w_q.size(), n);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // Raise one request, measure ticks until its ack, then release it
  task automatic req_one(input bit sel, input logic [15:0] d, output int lat);
    lat = 0;
    if (sel) begin data1 = d; req1 = 1'b1; end
    else     begin data0 = d; req0 = 1'b1; end
    do begin
      tick();
      lat++;
    end while (!(sel ? ack1 : ack0) && lat < 20);
    if (sel) req1 = 1'b0; else req0 = 1'b0;
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] dat;
    logic [15:0] exp_word;
    bit          exp_gid;
    int          exp_len;
    int          exp_lat;
    int          exp_bdrop;
  } vec_t;

  vec_t vt[5];

  initial begin
    int   lat, k, nack;
    bit   rearm;
    logic exp_g[4];

    vt[0] = '{sel:1'b0, dat:16'hA5C3, exp_word:16'hA5C3, exp_gid:1'b0, exp_len:68, exp_lat:1, exp_bdrop:4};
    vt[1] = '{sel:1'b1, dat:16'h5AA5, exp_word:16'h5AA5, exp_gid:1'b1, exp_len:68, exp_lat:1, exp_bdrop:4};
    vt[2] = '{sel:1'b0, dat:16'hFFFF, exp_word:16'hFFFF, exp_gid:1'b0, exp_len:68, exp_lat:1, exp_bdrop:4};
    vt[3] = '{sel:1'b1, dat:16'h0001, exp_word:16'h0001, exp_gid:1'b1, exp_len:68, exp_lat:1, exp_bdrop:4};
    vt[4] = '{sel:1'b0, dat:16'h8000, exp_word:16'h8000, exp_gid:1'b0, exp_len:68, exp_lat:1, exp_bdrop:4};

    rst_n = 1'b0; en = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_data0 = '0; b_data1 = '0;

    // Reset values
    #1;
    chk("rst_cs_n",     {31'd0, cs_n},     32'd1);
    chk("rst_sclk",     {31'd0, sclk},     32'd0);
    chk("rst_mosi",     {31'd0, mosi},     32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_ack0",     {31'd0, ack0},     32'd0);
    chk("rst_ack1",     {31'd0, ack1},     32'd0);
    chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
    chk("rst_b_cs_n",   {31'd0, b_cs_n},   32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single-request frames from the vector table
    for (int i = 0; i < 5; i++) begin
      clear_q();
      req_one(vt[i].sel, vt[i].dat, lat);
      chk($sformatf("v%0d_ack_lat", i), lat, vt[i].exp_lat);
      wait_frames(1, $sformatf("v%0d_frame_seen", i));
      wait_idle($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_word", i), {16'd0, w_q[0]}, {16'd0, vt[i].exp_word});
      chk($sformatf("v%0d_cs_low", i), len_q[0], vt[i].exp_len);
      chk($sformatf("v%0d_grant_id", i), {31'd0, g_q[0]}, {31'd0, vt[i].exp_gid});
      chk($sformatf("v%0d_ack_count", i), ack_q.size(), 1);
      chk($sformatf("v%0d_busy_drop", i),
          (bfall_q.size() > 0 && done_q.size() > 0) ? bfall_q[0] - done_q[0] : -1,
          vt[i].exp_bdrop);
    end

    // Simultaneous requests straight after reset: requester 0 wins the tie
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    clear_q();
    data0 = 16'h1111; data1 = 16'h2222; req0 = 1'b1; req1 = 1'b1;
    k = 0;
    while (w_q.size() < 2 && k < 1000) begin
      tick(); k++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("sim_frames", w_q.size(), 2);
    wait_idle("sim_idle");
    chk("sim_word0", {16'd0, w_q[0]}, 32'h1111);
    chk("sim_word1", {16'd0, w_q[1]}, 32'h2222);
    chk("sim_gid0", {31'd0, g_q[0]}, 32'd0);
    chk("sim_gid1", {31'd0, g_q[1]}, 32'd1);
    chk("sim_gap_to_fall",
        (fall_q.size() > 1 && done_q.size() > 0) ? fall_q[1] - done_q[0] : -1, 5);

    // Fairness: req1 held, req0 re-raised after each ack
    clear_q();
    data0 = 16'h0A0A; data1 = 16'h0B0B; req0 = 1'b1; req1 = 1'b1;
    nack = 0; rearm = 1'b0; k = 0;
    while (nack < 4 && k < 1000) begin
      tick(); k++;
      if (rearm) begin req0 = 1'b1; rearm = 1'b0; end
      if (ack0 || ack1) nack++;
      if (ack0) begin req0 = 1'b0; rearm = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_frames(4, "fair_frames");
    wait_idle("fair_idle");
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fair_gid%0d", i), {31'd0, g_q[i]}, {31'd0, exp_g[i]});
      chk($sformatf("fair_word%0d", i), {16'd0, w_q[i]}, exp_g[i] ? 32'h0B0B : 32'h0A0A);
    end
    chk("fair_ack_count", ack_q.size(), 4);

    // en gating: dropped mid-frame with req1 pending
    clear_q();
    req_one(1'b0, 16'hC3C3, lat);
    data1 = 16'h3C3C; req1 = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    wait_frames(1, "en_frame1_seen");
    wait_idle("en_idle");
    repeat (8) tick();
    chk("en_no_ack1_while_low", ack_q.size(), 1);
    en = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!ack1 && lat < 20);
    req1 = 1'b0;
    chk("en_resume_lat", lat, 1);
    chk("en_resume_cs_n", {31'd0, cs_n}, 32'd0);
    wait_frames(2, "en_frames");
    wait_idle("en_idle2");
    chk("en_word0", {16'd0, w_q[0]}, 32'hC3C3);
    chk("en_len0", len_q[0], 68);
    chk("en_word1", {16'd0, w_q[1]}, 32'h3C3C);

    // Reset in the middle of SHIFT, with both requesters pending
    clear_q();
    req_one(1'b0, 16'hFFFF, lat);
    k = 0;
    while (rises < 5 && k < 100) begin tick(); k++; end
    chk("mid_pre_sclk", {31'd0, sclk}, 32'd1);
    chk("mid_pre_mosi", {31'd0, mosi}, 32'd1);
    chk("mid_pre_busy", {31'd0, busy}, 32'd1);
    data0 = 16'h1234; data1 = 16'h5678; req0 = 1'b1; req1 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_rst_mosi", {31'd0, mosi}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("mid_rst_held_cs_n", {31'd0, cs_n}, 32'd1);
    clear_q();
    rst_n = 1'b1;
    k = 0;
    while (w_q.size() < 2 && k < 1000) begin
      tick(); k++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("mid_frames", w_q.size(), 2);
    wait_idle("mid_idle");
    chk("mid_first_ack_id", ack_q.size() > 0 ? {31'd0, ack_q[0]} : 32'd9, 32'd0);
    chk("mid_word0", {16'd0, w_q[0]}, 32'h1234);
    chk("mid_word1", {16'd0, w_q[1]}, 32'h5678);

    // Small instance: DIV_N=1, DATA_W=8
    b_data0 = 8'h81; b_req0 = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!b_ack0 && lat < 20);
    b_req0 = 1'b0;
    chk("b_ack_lat", lat, 1);
    k = 0;
    while (bw_q.size() < 1 && k < 200) begin tick(); k++; end
    chk("b_frames", bw_q.size(), 1);
    chk("b_word", {24'd0, bw_q[0]}, 32'h81);
    chk("b_cs_low", blen_q[0], 18);
    chk("b_rises", b_rises, 8);
    chk("b_period_count", b_nper, 7);
    chk("b_bad_periods", b_badper, 0);

    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nerrs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", ntests, nerrs);
    $fatal(1);
  end

endmodule
